// File: rtl/medidor_pulso.sv
// Pulse-width meter: arm with mede, then count the clocks of the next rising-edge pulse on pulso.
// Define MEDIDOR_PULSO_SYNC_EN to pass pulso through a two-flop synchronizer first (+2 cycles latency).
module medidor_pulso #(
    parameter int          N       = 32,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mede,
    input  logic         cancela,
    input  logic         pulso,
    output logic [N-1:0] largura,
    output logic         pronto,
    output logic         timeout,
    output logic         ocupado
);

    typedef enum logic [2:0] {
        ST_PARADO,
        ST_ESPERA_SUBIDA,
        ST_MEDINDO,
        ST_FINAL,
        ST_FIM_TIMEOUT
    } estado_t;

    localparam logic [N-1:0] LIMITE    = N'(TIMEOUT);
    localparam logic [N-1:0] LIMITE_M1 = N'(TIMEOUT - 1);

    estado_t      estado_q, estado_d;
    logic [N-1:0] cont_q, cont_d;
    logic [N-1:0] largura_q, largura_d;
    logic         p;
    logic         p_d_q;
    logic         subida;

`ifdef MEDIDOR_PULSO_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pulso};
        end
    end

    assign p = sync_q[1];
`else
    assign p = pulso;
`endif

    // The edge cycle itself is the first high cycle of the measured pulse.
    assign subida = p & ~p_d_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= ST_PARADO;
            cont_q    <= '0;
            largura_q <= '0;
            p_d_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cont_q    <= cont_d;
            largura_q <= largura_d;
            p_d_q     <= p;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        largura_d = largura_q;
        case (estado_q)
            ST_PARADO: begin
                cont_d = '0;
                if (mede) begin
                    estado_d = ST_ESPERA_SUBIDA;
                end
            end
            ST_ESPERA_SUBIDA: begin
                if (cancela) begin
                    estado_d = ST_PARADO;
                end else if (subida) begin
                    estado_d = ST_MEDINDO;
                    cont_d   = N'(1);
                end else if (cont_q == LIMITE_M1) begin
                    estado_d = ST_FIM_TIMEOUT;
                end else begin
                    cont_d = cont_q + N'(1);
                end
            end
            ST_MEDINDO: begin
                if (cancela) begin
                    estado_d = ST_PARADO;
                end else if (!p) begin
                    largura_d = cont_q;
                    estado_d  = ST_FINAL;
                end else if (cont_q == LIMITE) begin
                    estado_d = ST_FIM_TIMEOUT;
                end else begin
                    cont_d = cont_q + N'(1);
                end
            end
            ST_FINAL: begin
                estado_d = ST_PARADO;
            end
            ST_FIM_TIMEOUT: begin
                largura_d = '0;
                estado_d  = ST_PARADO;
            end
            default: begin
                estado_d = ST_PARADO;
            end
        endcase
    end

    assign largura = largura_q;
    assign pronto  = (estado_q == ST_FINAL);
    assign timeout = (estado_q == ST_FIM_TIMEOUT);
    assign ocupado = (estado_q == ST_ESPERA_SUBIDA) || (estado_q == ST_MEDINDO);

endmodule

// File: tb/tb_medidor_pulso.sv
// Bench for medidor_pulso: per-transaction pulse patterns, expected strobes/width derived
// from the pattern by scanning for the first rising edge and counting its high run.
module tb_medidor_pulso;
    localparam int N  = 32;
    localparam int TM = 100;
    localparam int AW = 256;
`ifdef MEDIDOR_PULSO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         mede;
    logic         cancela;
    logic         pulso;
    logic [N-1:0] largura;
    logic         pronto;
    logic         timeout;
    logic         ocupado;

    medidor_pulso #(.N(N), .TIMEOUT(TM)) dut (
        .clock   (clock),
        .reset   (reset),
        .mede    (mede),
        .cancela (cancela),
        .pulso   (pulso),
        .largura (largura),
        .pronto  (pronto),
        .timeout (timeout),
        .ocupado (ocupado)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          passed = 0;
    bit          chk_en = 1'b0;
    logic        exp_ocup = 1'b0;
    logic        exp_pr = 1'b0;
    logic        exp_to = 1'b0;
    logic [31:0] exp_larg = '0;
    logic [N-1:0] exp_q[$];

    logic pat[AW];
    logic hist[2];
    int   cancel_at = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Every cycle: outputs against the expectation set by the driver for this cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            check("ocupado", 32'(ocupado), 32'(exp_ocup));
            check("pronto", 32'(pronto), 32'(exp_pr));
            check("timeout", 32'(timeout), 32'(exp_to));
            check("largura", 32'(largura), exp_larg);
            if (pronto === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("pronto_unexpected", 32'(1), 32'(0));
                end else begin
                    check("largura_at_pronto", 32'(largura), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic pval);
        for (int i = 0; i < n; i++) begin
            mede     = 1'b0;
            cancela  = 1'b0;
            pulso    = pval;
            exp_ocup = 1'b0;
            exp_pr   = 1'b0;
            exp_to   = 1'b0;
            hist[1]  = hist[0];
            hist[0]  = pval;
            step();
        end
    endtask

    task automatic make_pat(input int pre_hi, input int start, input int width);
        for (int i = 0; i < AW; i++) begin
            pat[i] = (i < pre_hi) || (i >= start && i < start + width);
        end
    endtask

    // Arms at relative cycle 0 and plays pat[]; expected behaviour comes from
    // the first rising edge seen within TM waiting cycles and the length of its high run.
    task automatic run_txn(output int kind, output int w);
        logic pp[AW];
        int j;
        int r;
        int busy_end;
        int s;
        int last;
        for (int i = 0; i < AW; i++) begin
            pp[i] = (i >= LAT) ? pat[i - LAT] : hist[LAT - 1 - i];
        end
        j = 0;
        for (int e = 1; e <= TM; e++) begin
            if (j == 0 && pp[e] && !pp[e - 1]) j = e;
        end
        w = 0;
        if (j == 0) begin
            kind = 2; busy_end = TM; s = TM + 1;
        end else begin
            r = 0;
            while (j + r < AW && pp[j + r]) r++;
            if (r <= TM) begin
                kind = 1; w = r; busy_end = j + r; s = j + r + 1;
            end else begin
                kind = 2; busy_end = j + TM; s = j + TM + 1;
            end
        end
        last = s;
        if (cancel_at >= 1 && cancel_at <= busy_end) begin
            kind = 0; w = 0; busy_end = cancel_at; last = cancel_at + 1;
        end
        for (int i = 0; i <= last; i++) begin
            mede     = (i == 0);
            cancela  = (i == cancel_at);
            pulso    = pat[i];
            exp_ocup = (i >= 1 && i <= busy_end);
            exp_pr   = (kind == 1 && i == s);
            exp_to   = (kind == 2 && i == s);
            if (kind == 1 && i == s) begin
                exp_larg = 32'(w);
                exp_q.push_back(N'(w));
            end
            hist[1] = hist[0];
            hist[0] = pat[i];
            step();
        end
        if (kind == 2) exp_larg = '0;
        mede      = 1'b0;
        cancela   = 1'b0;
        cancel_at = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kind;
        int w;
        reset   = 1'b1;
        mede    = 1'b0;
        cancela = 1'b0;
        pulso   = 1'b0;
        hist[0] = 1'b0;
        hist[1] = 1'b0;
        #1;
        check("reset_largura", largura, 32'd0);
        check("reset_pronto", 32'(pronto), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_ocupado", 32'(ocupado), 32'd0);
        step();
        step();
        reset  = 1'b0;
        chk_en = 1'b1;
        idle(3, 1'b0);

        // nominal 25-cycle pulse starting 3 cycles after arm
        make_pat(0, 3, 25);
        run_txn(kind, w);
        check("model_nominal_w", 32'(w), 32'd25);
        check("nominal_largura", largura, 32'd25);
        check("nominal_ocupado_after", 32'(ocupado), 32'd0);

        // back-to-back 7-wide pulses, re-armed on the cycle after the strobe
        make_pat(0, 1, 7);
        run_txn(kind, w);
        check("b2b_first", largura, 32'd7);
        run_txn(kind, w);
        check("b2b_second", largura, 32'd7);
        idle(2, 1'b1);

        // pulso already high when armed: only the later 10-cycle pulse counts
        make_pat(2, 4, 10);
        run_txn(kind, w);
        check("high_at_arm", largura, 32'd10);
        idle(2, 1'b0);

        // no edge at all
        make_pat(0, 0, 0);
        run_txn(kind, w);
        check("wait_timeout_kind", 32'(kind), 32'd2);
        check("wait_timeout_largura", largura, 32'd0);
        idle(2, 1'b0);

        // width limit: TM measures, TM+1 times out
        make_pat(0, 1, TM);
        run_txn(kind, w);
        check("limit_exact", largura, 32'(TM));
        idle(2, 1'b0);
        make_pat(0, 1, TM + 1);
        run_txn(kind, w);
        check("limit_over_kind", 32'(kind), 32'd2);
        check("limit_over_largura", largura, 32'd0);
        idle(2, 1'b0);

        // edge arriving on the very last waiting cycle still wins
        make_pat(0, TM - LAT, 5);
        run_txn(kind, w);
        check("edge_at_limit", largura, 32'd5);
        idle(2, 1'b0);

        // cancel at high-cycle 5 of a 20-cycle pulse
        make_pat(0, 2, 20);
        cancel_at = 6;
        run_txn(kind, w);
        check("abort_largura_kept", largura, 32'd5);
        check("abort_ocupado", 32'(ocupado), 32'd0);
        idle(20, 1'b0);

        // reset mid-measurement
        chk_en  = 1'b0;
        mede    = 1'b1;
        pulso   = 1'b0;
        step();
        mede    = 1'b0;
        step();
        pulso   = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("busy_before_reset", 32'(ocupado), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_largura", largura, 32'd0);
        check("rst_mid_pronto", 32'(pronto), 32'd0);
        check("rst_mid_timeout", 32'(timeout), 32'd0);
        check("rst_mid_ocupado", 32'(ocupado), 32'd0);
        step();
        reset    = 1'b0;
        pulso    = 1'b0;
        exp_larg = '0;
        hist[0]  = 1'b0;
        hist[1]  = 1'b0;
        chk_en   = 1'b1;
        idle(3, 1'b0);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            int pre_hi;
            int start;
            int width;
            pre_hi = $urandom_range(0, 3);
            start  = pre_hi + $urandom_range(0, TM + 4);
            if ($urandom_range(0, 3) == 0) width = $urandom_range(TM - 2, TM + 2);
            else width = $urandom_range(1, 40);
            make_pat(pre_hi, start, width);
            if ($urandom_range(0, 5) == 0) cancel_at = $urandom_range(1, start + width);
            idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            run_txn(kind, w);
        end
        idle(3, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
